card_dealer: RTL and testbench



---
 rtl/card_dealer.sv | 185 ++++++++++++++++++
 tb/tb_card_dealer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer: 52-card deck source for the ten-thirty pip/number draw protocol (fill, LFSR Fisher-Yates shuffle, deal).
// Latency: one card per pip, number/valid registered one cycle after pip is sampled; shuffle time varies with the LFSR.
// Backpressure: none; pips outside READY (or at an empty deck) are dropped and flagged on pip_drop.
// Build option: define CARD_DEALER_NO_SHUFFLE_EN to skip all swaps (deals come out in fill order 1..13,1..).
module card_dealer #(
  parameter int unsigned DECK_SIZE = 52,
  parameter logic [6:0]  LFSR_SEED = 7'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pip,
  input  logic       shuffle,
  output logic [3:0] number,
  output logic       valid,
  output logic       ready,
  output logic       pip_drop,
  output logic [5:0] cards_left
);

  // Deck positions and the deal pointer both fit in 6 bits (deck is at most 63 cards).
  localparam logic [5:0] FULL = 6'(DECK_SIZE);
  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_SHUFFLE = 2'd1,
    S_READY   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [6:0] lfsr;
  logic [5:0] idx;        // fill index while filling, Fisher-Yates index while shuffling
  logic [5:0] ptr;        // next card to deal
  logic [3:0] fill_rank;  // rank written at deck[idx] during fill, wraps 13 -> 1
  logic [3:0] deck [DECK_SIZE];

  logic       deck_empty;
  logic       fill_we;
  logic       swap_en;
  logic       deal_en;
  logic       drop_en;
  logic       load_top;
  logic       ptr_clr;

  assign deck_empty = (ptr == FULL);

  // State register; reset always restarts from a fresh fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fill -> shuffle -> ready, and back to shuffle on an empty-deck pip or a lone shuffle request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (idx == LAST) begin
`ifdef CARD_DEALER_NO_SHUFFLE_EN
          state_nxt = S_READY;
`else
          state_nxt = S_SHUFFLE;
`endif
        end
      end
      S_SHUFFLE: begin
`ifdef CARD_DEALER_NO_SHUFFLE_EN
        state_nxt = S_READY;
`else
        if (idx == 6'd0) begin
          state_nxt = S_READY;
        end
`endif
      end
      S_READY: begin
        // A pip with cards left always wins over a simultaneous shuffle request.
        if (pip && deck_empty) begin
          state_nxt = S_SHUFFLE;
        end else if (!pip && shuffle) begin
          state_nxt = S_SHUFFLE;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // Output/control decode from the current state and inputs.
  always_comb begin
    ready    = 1'b0;
    fill_we  = 1'b0;
    swap_en  = 1'b0;
    deal_en  = 1'b0;
    load_top = 1'b0;
    ptr_clr  = 1'b0;
    case (state)
      S_FILL: begin
        fill_we  = 1'b1;
        load_top = (idx == LAST);
      end
      S_SHUFFLE: begin
`ifdef CARD_DEALER_NO_SHUFFLE_EN
        ptr_clr = 1'b1;
`else
        if (idx == 6'd0) begin
          ptr_clr = 1'b1;
        end else begin
          // Candidates above idx are rejected rather than reduced mod (idx+1), keeping picks uniform-ish.
          swap_en = (lfsr[5:0] <= idx);
        end
`endif
      end
      S_READY: begin
        ready = 1'b1;
        if (pip && !deck_empty) begin
          deal_en = 1'b1;
        end else if (pip || shuffle) begin
          load_top = 1'b1;
        end
      end
      default: begin
        ready = 1'b0;
      end
    endcase
    // Any pip that does not produce a card is reported, so valid and pip_drop are exclusive.
    drop_en = pip && !deal_en;
  end

  // LFSR, indices, deal pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr       <= LFSR_SEED;
      idx        <= 6'd0;
      ptr        <= 6'd0;
      fill_rank  <= 4'd1;
      number     <= 4'd0;
      valid      <= 1'b0;
      pip_drop   <= 1'b0;
      cards_left <= FULL;
    end else begin
      // x^7 + x^6 + 1 Fibonacci LFSR, free-running outside reset.
      lfsr     <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      valid    <= deal_en;
      pip_drop <= drop_en;

      if (fill_we) begin
        fill_rank <= (fill_rank == 4'd13) ? 4'd1 : fill_rank + 4'd1;
      end

      if (load_top) begin
        idx <= LAST;
      end else if (fill_we) begin
        idx <= idx + 6'd1;
      end else if (swap_en) begin
        idx <= idx - 6'd1;
      end

      if (deal_en) begin
        number     <= deck[ptr];
        ptr        <= ptr + 6'd1;
        cards_left <= FULL - (ptr + 6'd1);
      end else if (ptr_clr) begin
        ptr        <= 6'd0;
        cards_left <= FULL;
      end
    end
  end

  // Deck storage: sequential fill, then in-place swaps; contents survive reshuffles as a permutation.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (fill_we) begin
        deck[idx] <= fill_rank;
      end else if (swap_en) begin
        deck[idx]        <= deck[lfsr[5:0]];
        deck[lfsr[5:0]]  <= deck[idx];
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer: reference model keeps the deck as an array and applies the shuffle rules directly.
module tb_card_dealer;

  localparam int         N    = 52;
  localparam logic [6:0] SEED = 7'h5A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pip = 1'b0;
  logic       shuffle = 1'b0;
  logic [3:0] number;
  logic       valid;
  logic       ready;
  logic       pip_drop;
  logic [5:0] cards_left;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] mdeck [N];
  logic [3:0] first_seq [N];
  int         mptr = 0;
  logic [3:0] last_num = 4'd0;

  card_dealer #(.DECK_SIZE(N), .LFSR_SEED(SEED)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pip(pip),
    .shuffle(shuffle),
    .number(number),
    .valid(valid),
    .ready(ready),
    .pip_drop(pip_drop),
    .cards_left(cards_left)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset edge; the LFSR value is seed stepped this many times.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  function automatic logic [6:0] lfsr_at(input int n);
    logic [6:0] v;
    v = SEED;
    for (int k = 0; k < n; k++) v = lfsr_next(v);
    return v;
  endfunction

  task automatic model_fill();
    for (int k = 0; k < N; k++) mdeck[k] = 4'((k % 13) + 1);
    mptr = 0;
  endtask

  // Fisher-Yates with rejection: candidate = low 6 LFSR bits, one candidate per cycle.
  task automatic model_shuffle(input logic [6:0] start);
`ifndef CARD_DEALER_NO_SHUFFLE_EN
    logic [6:0] v;
    logic [3:0] t;
    int i;
    int j;
    v = start;
    i = N - 1;
    while (i > 0) begin
      j = int'(v[5:0]);
      if (j <= i) begin
        t = mdeck[i];
        mdeck[i] = mdeck[j];
        mdeck[j] = t;
        i--;
      end
      v = lfsr_next(v);
    end
`endif
    mptr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 10000) begin
      tick();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: ready timeout, ready=%b required 1", tag, ready);
    end
  endtask

  // Deal n cards with random idle gaps; check each card against the model.
  task automatic deal_block(input int n, input string tag, input bit check_multiset);
    int cnt [14];
    int gap;
    for (int r = 0; r < 14; r++) cnt[r] = 0;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        pip = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL %s idle valid: got %b required 0", tag, valid);
        end
      end
      pip = 1'b1;
      tick();
      checks++;
      if (valid !== 1'b1 || pip_drop !== 1'b0) begin
        errors++;
        $display("FAIL %s card %0d valid/pip_drop: got %b/%b required 1/0", tag, k, valid, pip_drop);
      end
      checks++;
      if (number !== mdeck[mptr]) begin
        errors++;
        $display("FAIL %s card %0d number: got %0d required %0d", tag, k, number, mdeck[mptr]);
      end
      checks++;
      if (cards_left !== 6'(N - mptr - 1)) begin
        errors++;
        $display("FAIL %s card %0d cards_left: got %0d required %0d", tag, k, cards_left, N - mptr - 1);
      end
      cnt[mdeck[mptr]]++;
      last_num = mdeck[mptr];
      mptr++;
    end
    pip = 1'b0;
    if (check_multiset) begin
      for (int r = 1; r <= 13; r++) begin
        checks++;
        if (cnt[r] != N / 13) begin
          errors++;
          $display("FAIL %s rank %0d count: got %0d required %0d", tag, r, cnt[r], N / 13);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (number !== 4'd0 || valid !== 1'b0 || ready !== 1'b0 || pip_drop !== 1'b0 || cards_left !== 6'd52) begin
      errors++;
      $display("FAIL reset outputs: number=%0d valid=%b ready=%b pip_drop=%b cards_left=%0d required 0/0/0/0/52",
               number, valid, ready, pip_drop, cards_left);
    end
    rst_n = 1'b1;
    pip = 1'b1;
    tick();
    pip = 1'b0;
    checks++;
    if (pip_drop !== 1'b1 || valid !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL pip during fill: pip_drop=%b valid=%b ready=%b required 1/0/0", pip_drop, valid, ready);
    end
    model_fill();
    model_shuffle(lfsr_at(N));
    for (int k = 0; k < N; k++) first_seq[k] = mdeck[k];
    wait_ready("first ready");
    checks++;
    if (cards_left !== 6'd52 || number !== 4'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL first ready outputs: cards_left=%0d number=%0d valid=%b required 52/0/0", cards_left, number, valid);
    end
  endtask

  task automatic test_deal_full();
    deal_block(N, "deal_full", 1'b1);
  endtask

  task automatic test_empty_reshuffle();
    pip = 1'b1;
    tick();
    pip = 1'b0;
    checks++;
    if (pip_drop !== 1'b1 || valid !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL empty pip: pip_drop=%b valid=%b ready=%b required 1/0/0", pip_drop, valid, ready);
    end
    checks++;
    if (number !== last_num || cards_left !== 6'd0) begin
      errors++;
      $display("FAIL empty hold: number=%0d cards_left=%0d required %0d/0", number, cards_left, last_num);
    end
    model_shuffle(lfsr_at(cyc));
    wait_ready("reshuffle ready");
    checks++;
    if (cards_left !== 6'd52) begin
      errors++;
      $display("FAIL reshuffle cards_left: got %0d required 52", cards_left);
    end
    deal_block(N, "deal_reshuffled", 1'b1);
  endtask

  task automatic test_pip_and_shuffle();
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    checks++;
    if (ready !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL shuffle request: ready=%b valid=%b required 0/0", ready, valid);
    end
    model_shuffle(lfsr_at(cyc));
    wait_ready("shuffle ready");
    deal_block(22, "deal_to_30", 1'b0);
    checks++;
    if (cards_left !== 6'd30) begin
      errors++;
      $display("FAIL cards_left before collision: got %0d required 30", cards_left);
    end
    pip = 1'b1;
    shuffle = 1'b1;
    tick();
    pip = 1'b0;
    shuffle = 1'b0;
    checks++;
    if (valid !== 1'b1 || number !== mdeck[mptr] || cards_left !== 6'd29 || ready !== 1'b1) begin
      errors++;
      $display("FAIL pip+shuffle: valid=%b number=%0d cards_left=%0d ready=%b required 1/%0d/29/1",
               valid, number, cards_left, ready, mdeck[mptr]);
    end
    mptr++;
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    checks++;
    if (ready !== 1'b0 || cards_left !== 6'd29) begin
      errors++;
      $display("FAIL lone shuffle: ready=%b cards_left=%0d required 0/29", ready, cards_left);
    end
    model_shuffle(lfsr_at(cyc));
    wait_ready("lone shuffle ready");
    checks++;
    if (cards_left !== 6'd52) begin
      errors++;
      $display("FAIL lone shuffle cards_left: got %0d required 52", cards_left);
    end
    deal_block(5, "deal_after_shuffle", 1'b0);
  endtask

  task automatic test_reset_mid_shuffle();
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (number !== 4'd0 || valid !== 1'b0 || ready !== 1'b0 || pip_drop !== 1'b0 || cards_left !== 6'd52) begin
      errors++;
      $display("FAIL mid-shuffle reset: number=%0d valid=%b ready=%b pip_drop=%b cards_left=%0d required 0/0/0/0/52",
               number, valid, ready, pip_drop, cards_left);
    end
    wait_ready("post-reset ready");
    pip = 1'b1;
    for (int k = 0; k < N; k++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || number !== first_seq[k]) begin
        errors++;
        $display("FAIL post-reset card %0d: valid=%b number=%0d required 1/%0d", k, valid, number, first_seq[k]);
      end
    end
    pip = 1'b0;
  endtask

  initial begin
    test_reset();
    test_deal_full();
    test_empty_reshuffle();
    test_pip_and_shuffle();
    test_reset_mid_shuffle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
